// File: rtl/ps2_keys_rx.sv
// ps2_keys_rx: PS/2 keyboard receiver producing the held paddle-key vector.
// Synchronises the PS/2 pins, deframes 11-bit frames, and decodes make/break
// scancodes (with the E0 prefix) into held-key bits: [0]=up, [1]=down.
// Optional feature macro: PS2_PARITY_CHECK_EN enables the odd-parity check
// in the STOP state. Without it the parity bit is clocked through and ignored.
// KEYS_W sets the keys_o width; it defaults to 2 and any extra bits read 0.

`ifndef KEYS_W
`define KEYS_W 2
`endif

module ps2_keys_rx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIMEOUT_US  = 200
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ps2_clk_i,
    input  logic               ps2_data_i,
    output logic [`KEYS_W-1:0] keys_o,
    output logic [7:0]         scancode_o,
    output logic               scancode_valid_o,
    output logic               frame_err_o
);

    localparam int TO_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int WD_W   = $clog2(TO_CYC + 1);
    localparam logic [WD_W-1:0] TO_VAL = WD_W'(TO_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchroniser and edge-detect registers (idle high).
    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;

    // Frame deframer state.
    state_t          r_state;
    state_t          w_next_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [WD_W-1:0] r_wd;
`ifdef PS2_PARITY_CHECK_EN
    logic            r_parity;
`endif

    // Decode state.
    logic            r_ext, r_brk;
    logic [1:0]      r_keys;

    // Combinational control.
    logic            w_strobe;
    logic            w_dat;
    logic            w_timeout;
    logic            w_accept;
    logic            w_err;
    logic            w_hit_up, w_hit_dn;

    assign w_strobe  = r_clk_prev & ~r_clk_s2;
    assign w_dat     = r_dat_s2;
    assign w_timeout = (r_state != S_IDLE) && (r_wd == TO_VAL);
    assign w_hit_up  = ( r_ext && (r_shift == 8'h75)) || (!r_ext && (r_shift == 8'h1D));
    assign w_hit_dn  = ( r_ext && (r_shift == 8'h72)) || (!r_ext && (r_shift == 8'h1B));

    // Two-flop synchronisers on both pins plus the previous synced clock.
    // NOTE: every sequential block uses non-blocking (<=) so all registers
    // update from pre-edge values; blocking here would collapse the 2-FF chain.
    // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
    // takes effect without a clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_i;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_i;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Frame FSM next state, plus accept/error decisions made on the stop strobe.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_err        = 1'b0;
        if (w_timeout) begin
            w_next_state = S_IDLE;
            w_err        = 1'b1;
        end else if (w_strobe) begin
            case (r_state)
                S_IDLE:   if (!w_dat) w_next_state = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_next_state = S_PARITY;
                S_PARITY: w_next_state = S_STOP;
                S_STOP: begin
                    w_next_state = S_IDLE;
                    if (!w_dat) begin
                        w_err = 1'b1;
                    end else begin
`ifdef PS2_PARITY_CHECK_EN
                        if (^{r_shift, r_parity}) w_accept = 1'b1;
                        else                      w_err    = 1'b1;
`else
                        w_accept = 1'b1;
`endif
                    end
                end
                default:  w_next_state = S_IDLE;
            endcase
        end
    end

    // Deframer datapath: bit counter, LSB-first shifter, parity capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_strobe && !w_timeout) begin
            case (r_state)
                S_IDLE: r_bit_cnt <= 3'd0;
                S_DATA: begin
                    r_shift   <= {w_dat, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
`ifdef PS2_PARITY_CHECK_EN
                S_PARITY: r_parity <= w_dat;
`endif
                default: ;
            endcase
        end
    end

    // Frame watchdog: cleared while idle and on each strobe, saturating count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                             r_wd <= '0;
        else if (r_state == S_IDLE || w_strobe) r_wd <= '0;
        else if (r_wd != TO_VAL)                r_wd <= r_wd + WD_W'(1);
    end

    // Output pulses and scancode decode into ext/brk flags and held keys.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scancode_o       <= 8'h00;
            scancode_valid_o <= 1'b0;
            frame_err_o      <= 1'b0;
            r_ext            <= 1'b0;
            r_brk            <= 1'b0;
            r_keys           <= 2'b00;
        end else begin
            scancode_valid_o <= w_accept;
            frame_err_o      <= w_err;
            if (w_accept) begin
                scancode_o <= r_shift;
                if (r_shift == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    if (w_hit_up) r_keys[0] <= ~r_brk;
                    if (w_hit_dn) r_keys[1] <= ~r_brk;
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end else if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    // Key vector: only the two paddle bits are ever driven.
    always_comb begin
        keys_o      = '0;
        keys_o[1:0] = r_keys;
    end

endmodule

// File: tb/tb_ps2_keys_rx.sv
// tb_ps2_keys_rx: directed table-driven bench for ps2_keys_rx.
// The DUT is built for a 1 MHz clock so one clk cycle models 1 us: the PS/2
// clock period is 80 cycles and the frame watchdog expires after 200 cycles.
`timescale 1ns/1ps

module tb_ps2_keys_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [1:0] keys;
    logic [7:0] code;
    logic       valid;
    logic       ferr;

    int checks   = 0;
    int failures = 0;

    int cyc       = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int err_cyc   = 0;
    int last_fall = 0;
    logic [7:0] last_code = 8'h00;

    ps2_keys_rx #(
        .CLK_FREQ_HZ(1_000_000),
        .TIMEOUT_US (200)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ps2_clk_i       (ps2_clk),
        .ps2_data_i      (ps2_data),
        .keys_o          (keys),
        .scancode_o      (code),
        .scancode_valid_o(valid),
        .frame_err_o     (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cnt <= valid_cnt + 1;
                last_code <= code;
            end
            if (ferr) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // One PS/2 bit: data set up mid-high, 40-cycle low phase, 40-cycle high phase.
    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (20) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (40) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ bad_par);
        send_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad_stop;
        bit         bad_par;
        logic [1:0] keys;
        int         nvalid;
        int         nerr;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int v0, e0, d;

        // Expected results of each frame, applied in order from reset.
        vecs.push_back('{8'hE0, 0, 0, 2'b00, 1, 0});  // ext prefix
        vecs.push_back('{8'h75, 0, 0, 2'b01, 1, 0});  // up make
        vecs.push_back('{8'hE0, 0, 0, 2'b01, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 2'b01, 1, 0});
        vecs.push_back('{8'h75, 0, 0, 2'b00, 1, 0});  // up break
        vecs.push_back('{8'h1B, 0, 0, 2'b10, 1, 0});  // S make
        vecs.push_back('{8'h1D, 0, 0, 2'b11, 1, 0});  // W make
        vecs.push_back('{8'hF0, 0, 0, 2'b11, 1, 0});
        vecs.push_back('{8'h1B, 0, 0, 2'b01, 1, 0});  // S break
        vecs.push_back('{8'hF0, 0, 0, 2'b01, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 2'b00, 1, 0});  // W break
        vecs.push_back('{8'h1D, 1, 0, 2'b00, 0, 1});  // bad stop: dropped
        vecs.push_back('{8'h1D, 0, 0, 2'b01, 1, 0});  // next frame decodes
        vecs.push_back('{8'hF0, 0, 0, 2'b01, 1, 0});
        vecs.push_back('{8'h72, 1, 0, 2'b01, 0, 1});  // error clears brk
        vecs.push_back('{8'h1D, 0, 0, 2'b01, 1, 0});  // so this is a make
        vecs.push_back('{8'hF0, 0, 0, 2'b01, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 2'b00, 1, 0});
        vecs.push_back('{8'h75, 0, 0, 2'b00, 1, 0});  // non-ext 75 unmapped
        vecs.push_back('{8'hAA, 0, 0, 2'b00, 1, 0});  // unmapped
        vecs.push_back('{8'h72, 0, 0, 2'b00, 1, 0});  // non-ext 72 unmapped
`ifdef PS2_PARITY_CHECK_EN
        vecs.push_back('{8'h1D, 0, 1, 2'b00, 0, 1});  // even parity rejected
`else
        vecs.push_back('{8'h1D, 0, 1, 2'b01, 1, 0});  // parity ignored
`endif

        // Reset state, held before the clock has done anything useful.
        repeat (3) @(negedge clk);
        check("rst_keys", int'(keys), 0);
        check("rst_code", int'(code), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(ferr), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // A lone high data bit on a strobe is a glitch, not an error.
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        check("glitch_err", err_cnt, 0);
        check("glitch_valid", valid_cnt, 0);

        foreach (vecs[i]) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].code, vecs[i].bad_stop, vecs[i].bad_par);
            check($sformatf("v%0d_keys", i), int'(keys), int'(vecs[i].keys));
            check($sformatf("v%0d_valid", i), valid_cnt - v0, vecs[i].nvalid);
            check($sformatf("v%0d_err", i), err_cnt - e0, vecs[i].nerr);
            if (vecs[i].nvalid != 0)
                check($sformatf("v%0d_code", i), int'(last_code), int'(vecs[i].code));
        end

        // Watchdog: abandon a frame after 4 data bits, clock stays high.
        e0 = err_cnt;
        v0 = valid_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        d = last_fall;
        repeat (250) @(negedge clk);
        check("to_err", err_cnt - e0, 1);
        check("to_valid", valid_cnt - v0, 0);
        d = err_cyc - d;
        check("to_latency_200", int'(d >= 200 && d <= 208), 1);
        send_frame(8'h1B, 0, 0);
        check("to_after_down", int'(keys[1]), 1);
        check("to_after_code", int'(last_code), 8'h1B);

        // Reset mid-frame with both keys held.
        send_frame(8'h1D, 0, 0);
        check("pre_rst_keys", int'(keys), 3);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_keys", int'(keys), 0);
        check("async_rst_code", int'(code), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        v0 = valid_cnt;
        send_frame(8'hE0, 0, 0);
        check("post_rst_e0_keys", int'(keys), 0);
        send_frame(8'h72, 0, 0);
        check("post_rst_keys", int'(keys), 2);
        check("post_rst_valid", valid_cnt - v0, 2);
        check("post_rst_code", int'(code), 8'h72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
